// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, writeback bypass
// and the ID/EX pipeline register with flush/stall control.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pcplus4_d,
  input  logic        valid_d,
  output logic [4:0]  rs1_d,
  output logic [4:0]  rs2_d,
  input  logic [31:0] rf_r1,
  input  logic [31:0] rf_r2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wd,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_e,
  output logic [31:0] pc_e,
  output logic [31:0] pcplus4_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic        reg_write_e,
  output logic        mem_write_e,
  output logic        alu_src_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic        valid_e,
  output logic        illegal_e,
  output logic [1:0]  result_src_e,
  output logic [2:0]  alu_control_e
);

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        valid;
    logic        illegal;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
  } id_ex_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        legal;
  logic        dec_reg_write;
  logic        dec_mem_write;
  logic        dec_alu_src;
  logic        dec_branch;
  logic        dec_jump;
  logic [1:0]  dec_result_src;
  logic [2:0]  dec_alu_control;
  logic [31:0] imm;
  logic [31:0] rd1;
  logic [31:0] rd2;
  id_ex_t      id_ex_d;
  id_ex_t      id_ex_q;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];
  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];

  always_comb begin
    legal           = 1'b0;
    dec_reg_write   = 1'b0;
    dec_mem_write   = 1'b0;
    dec_alu_src     = 1'b0;
    dec_branch      = 1'b0;
    dec_jump        = 1'b0;
    dec_result_src  = 2'b00;
    dec_alu_control = ALU_ADD;
    imm             = 32'd0;
    case (opcode)
      OP_R: begin
        dec_reg_write = 1'b1;
        legal         = 1'b1;
        if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_alu_control = ALU_SUB;
        end else if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_alu_control = ALU_ADD;
            3'b111:  dec_alu_control = ALU_AND;
            3'b110:  dec_alu_control = ALU_OR;
            3'b010:  dec_alu_control = ALU_SLT;
            default: legal = 1'b0;
          endcase
        end else begin
          legal = 1'b0;
        end
      end
      OP_IALU: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        legal         = 1'b1;
        imm           = {{20{instr_d[31]}}, instr_d[31:20]};
        case (funct3)
          3'b000:  dec_alu_control = ALU_ADD;
          3'b111:  dec_alu_control = ALU_AND;
          3'b110:  dec_alu_control = ALU_OR;
          3'b010:  dec_alu_control = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b01;
        legal          = (funct3 == 3'b010);
        imm            = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        legal         = (funct3 == 3'b010);
        imm           = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      end
      OP_BEQ: begin
        dec_branch      = 1'b1;
        dec_alu_control = ALU_SUB;
        legal           = (funct3 == 3'b000);
        imm = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      end
      OP_JAL: begin
        dec_jump       = 1'b1;
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b10;
        legal          = 1'b1;
        imm = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      end
      default: legal = 1'b0;
    endcase
  end

  // The register file writes on the next edge, so a same-cycle writeback must be forwarded here.
  always_comb begin
    rd1 = rf_r1;
    rd2 = rf_r2;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs1_d) rd1 = wb_wd;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs2_d) rd2 = wb_wd;
  end

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush_e) begin
      id_ex_d = '0;
    end else if (!stall_e) begin
      id_ex_d.rd1         = rd1;
      id_ex_d.rd2         = rd2;
      id_ex_d.imm         = imm;
      id_ex_d.pc          = pc_d;
      id_ex_d.pcplus4     = pcplus4_d;
      id_ex_d.rs1         = rs1_d;
      id_ex_d.rs2         = rs2_d;
      id_ex_d.rd          = instr_d[11:7];
      id_ex_d.valid       = valid_d;
      id_ex_d.illegal     = valid_d && !legal;
      // Illegal or empty slots carry no side effects downstream.
      if (valid_d && legal) begin
        id_ex_d.reg_write   = dec_reg_write;
        id_ex_d.mem_write   = dec_mem_write;
        id_ex_d.alu_src     = dec_alu_src;
        id_ex_d.branch      = dec_branch;
        id_ex_d.jump        = dec_jump;
        id_ex_d.result_src  = dec_result_src;
        id_ex_d.alu_control = dec_alu_control;
      end else begin
        id_ex_d.reg_write   = 1'b0;
        id_ex_d.mem_write   = 1'b0;
        id_ex_d.alu_src     = 1'b0;
        id_ex_d.branch      = 1'b0;
        id_ex_d.jump        = 1'b0;
        id_ex_d.result_src  = 2'b00;
        id_ex_d.alu_control = 3'b000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign rd1_e         = id_ex_q.rd1;
  assign rd2_e         = id_ex_q.rd2;
  assign imm_e         = id_ex_q.imm;
  assign pc_e          = id_ex_q.pc;
  assign pcplus4_e     = id_ex_q.pcplus4;
  assign rs1_e         = id_ex_q.rs1;
  assign rs2_e         = id_ex_q.rs2;
  assign rd_e          = id_ex_q.rd;
  assign reg_write_e   = id_ex_q.reg_write;
  assign mem_write_e   = id_ex_q.mem_write;
  assign alu_src_e     = id_ex_q.alu_src;
  assign branch_e      = id_ex_q.branch;
  assign jump_e        = id_ex_q.jump;
  assign valid_e       = id_ex_q.valid;
  assign illegal_e     = id_ex_q.illegal;
  assign result_src_e  = id_ex_q.result_src;
  assign alu_control_e = id_ex_q.alu_control;

endmodule
